// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared constants for the bit-serial subtractor.
// Holds the default width, the FSM encoding and the counter sizing helper.
package serial_subtractor_4bit_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH without wrapping.
    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_4bit_if.sv
// Request/result bundle of the bit-serial subtractor.
// The master drives operands and start; the slave returns result and status.
interface serial_subtractor_4bit_if
    import serial_subtractor_4bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, bin,
        input  diff, bout, busy, done
    );

    modport slave (
        input  start, a, b, bin,
        output diff, bout, busy, done
    );
endinterface

// File: rtl/serial_subtractor_4bit_full_subtractor.sv
// One-bit full subtractor used by the serial datapath.
// Computes x - y - bin as a difference bit plus a borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: one bit per clock, LSB first.
// IDLE captures operands, SHIFT walks the bits, DONE presents the result.
module serial_subtractor_4bit
    import serial_subtractor_4bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_subtractor_4bit_if.slave  bus
);
    localparam int CW = cnt_bits(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fs_d;
    logic             fs_b;

    full_subtractor u_fs (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_b)
    );

    // Next-state, datapath shifting and registered-output decode.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = fs_b;
                res_d    = {fs_d, res_q[WIDTH-2:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = {fs_d, res_q};
                    bout_d  = fs_b;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: doc/serial_subtractor_4bit.md
SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 4, operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a subtraction; sampled on clk.
REQ-005 The block SHALL have port a, input, WIDTH, minuend; sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH, subtrahend; sampled only when start is accepted.
REQ-007 The block SHALL have port bin, input, 1, borrow-in; sampled only when start is accepted.
REQ-008 The block SHALL have port diff, output, WIDTH, registered result.
REQ-009 The block SHALL have port bout, output, 1, registered borrow-out.
REQ-010 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse marking valid diff/bout.

Function
REQ-012 The block SHALL compute diff = (a - b - bin) mod 2^WIDTH and bout = 1 iff a < b + bin (unsigned).
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE, registered, with no other reachable state.
REQ-014 In IDLE, start=1 at an edge SHALL capture a, b, bin into internal shift registers, clear the bit counter and enter SHIFT.
REQ-015 In SHIFT, each edge SHALL process one bit, LSB first: difference bit = a_i ^ b_i ^ borrow; next borrow = (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
REQ-016 The borrow SHALL be held in a single flip-flop initialised from bin at capture.
REQ-017 After exactly WIDTH SHIFT edges, the FSM SHALL enter DONE, loading diff and bout on that same edge.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 done SHALL be high only in DONE, i.e. during the cycle after the WIDTH-th SHIFT edge; latency from the start-sampling edge to done high is WIDTH cycles.
REQ-020 busy SHALL be high exactly while in SHIFT; low in IDLE and DONE.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored, with no effect on the in-flight operation or the captured operands.
REQ-022 Changes on a, b and bin after capture SHALL NOT affect the result.
REQ-023 diff and bout SHALL hold their last result from DONE until the next DONE; they SHALL NOT change in IDLE or SHIFT.
REQ-024 Back-to-back operation SHALL be possible: start high in the IDLE cycle after DONE is accepted, giving a throughput of one result per WIDTH+2 cycles.
REQ-025 The bit counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-026 rst high SHALL asynchronously force the FSM to IDLE and set diff=0, bout=0, busy=0, done=0, borrow=0 and counter=0.
REQ-027 Reset asserted mid-operation SHALL abort it, and no done pulse SHALL follow for the aborted operation.
REQ-028 After rst deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Structure
REQ-029 WIDTH default and the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in the shared constants package/include.
REQ-030 The per-bit logic SHALL be a separate combinational sub-module, full_subtractor (ports x, y, bin, d, bout), instantiated once.
REQ-031 All outputs SHALL be driven directly from flip-flops.

Verification
REQ-032 Use WIDTH=4. Drive a=0101, b=0011, bin=0 with a start pulse: done SHALL go high 4 cycles later with diff=0010 and bout=0.
REQ-033 Drive a=0011, b=0101, bin=0: the bench SHALL check diff=1110 and bout=1.
REQ-034 Drive a=0000, b=0000, bin=1: the bench SHALL check diff=1111 and bout=1. Then drive a=1111, b=1111, bin=0: the bench SHALL check diff=0000 and bout=0.
REQ-035 After start with a=1000, b=0001, pulse start again with a=0000, b=1111 while busy: the bench SHALL check a single done with diff=0111 and bout=0.
REQ-036 Assert rst 2 cycles into SHIFT: the bench SHALL check that busy, done, diff and bout drop to 0 immediately and that no done pulse follows.
REQ-037 Hold start high continuously: the bench SHALL check done pulses every 6 cycles and busy low only in DONE and IDLE cycles.
